multicycle_sequencer: RTL

- Multi-cycle FSM controller for the 16-bit accumulator CPU. It sequences FETCH/DECODE/EXECUTE/MEMORY phases over a single shared memory port.
- It replaces the single-cycle opcode decoder and drives the PC, IR, R0, ALU and memory-port control strobes.
- It handles variable-latency memory through a req/ack handshake with a timeout.
- It keeps a retired-instruction counter.

---
 rtl/multicycle_sequencer_if.sv | 36 +++
 rtl/multicycle_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between the multicycle sequencer and the CPU datapath/memory.
// The master side is the sequencer; the slave side is the datapath and memory port.
interface multicycle_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [2:0]       opcode;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_ld;
    logic             pc_inc;
    logic             pc_ld;
    logic             r0_ld;
    logic             r0_src;
    logic             alu_sub;
    logic             swap_reg;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  start, opcode, zero, mem_ack,
        output mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld,
               r0_ld, r0_src, alu_sub, swap_reg, busy, halted, err, instr_cnt
    );

    modport slave (
        output start, opcode, zero, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld,
               r0_ld, r0_src, alu_sub, swap_reg, busy, halted, err, instr_cnt
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM controller for the 16-bit accumulator CPU with a shared,
// variable-latency memory port, access timeout and retired-instruction counter.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_sequencer_if.master bus_if
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_ERROR
    } state_t;

    localparam logic [2:0] OP_LDR = 3'b000;
    localparam logic [2:0] OP_STR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JEZ = 3'b101;
    localparam logic [2:0] OP_SWP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // wait_q holds the number of unacknowledged cycles already spent in the access.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        wait_d           = wait_q;
        cnt_d            = cnt_q;
        bus_if.mem_req   = 1'b0;
        bus_if.mem_we    = 1'b0;
        bus_if.addr_sel  = 1'b0;
        bus_if.ir_ld     = 1'b0;
        bus_if.pc_inc    = 1'b0;
        bus_if.pc_ld     = 1'b0;
        bus_if.r0_ld     = 1'b0;
        bus_if.r0_src    = 1'b0;
        bus_if.alu_sub   = 1'b0;
        bus_if.swap_reg  = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus_if.start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end

            S_FETCH: begin
                bus_if.mem_req = 1'b1;
                if (bus_if.mem_ack) begin
                    bus_if.ir_ld  = 1'b1;
                    bus_if.pc_inc = 1'b1;
                    state_d       = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_DECODE: begin
                op_d = bus_if.opcode;
                case (bus_if.opcode)
                    OP_LDR, OP_STR: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    OP_HLT:  state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end

            S_MEM: begin
                bus_if.mem_req  = 1'b1;
                bus_if.addr_sel = 1'b1;
                bus_if.mem_we   = (op_q == OP_STR);
                if (bus_if.mem_ack) begin
                    bus_if.r0_ld  = (op_q == OP_LDR);
                    bus_if.r0_src = (op_q == OP_LDR);
                    state_d       = S_FETCH;
                    wait_d        = '0;
                    cnt_d         = cnt_q + CNT_W'(1);
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_ADD:  bus_if.r0_ld = 1'b1;
                    OP_SUB: begin
                        bus_if.r0_ld   = 1'b1;
                        bus_if.alu_sub = 1'b1;
                    end
                    OP_JMP:  bus_if.pc_ld    = 1'b1;
                    OP_JEZ:  bus_if.pc_ld    = bus_if.zero;
                    OP_SWP:  bus_if.swap_reg = 1'b1;
                    default: ;
                endcase
                state_d = S_FETCH;
                wait_d  = '0;
                cnt_d   = cnt_q + CNT_W'(1);
            end

            S_ERROR: ;

            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                              (state_q == S_EXEC)  || (state_q == S_MEM);
    assign bus_if.halted    = (state_q == S_HALT);
    assign bus_if.err       = (state_q == S_ERROR);
    assign bus_if.instr_cnt = cnt_q;
endmodule
